// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: two-port arbitrated, wait-stated, range-checked access controller for the data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_access_ctrl #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int BASE_ADDR    = 1024,
  parameter int DEPTH        = 65465,
  parameter int WAIT_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDRESS_SIZE-1:0] addr0,
  input  logic [ADDRESS_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0]    wdata0,
  input  logic [WORD_SIZE-1:0]    wdata1,
  output logic                    ready0,
  output logic                    ready1,
  output logic [WORD_SIZE-1:0]    rdata,
  output logic                    err,
  output logic                    freeze,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]    mem_wdata,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [WORD_SIZE-1:0]    mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int AE = ADDRESS_SIZE + 1;
  localparam logic [AE-1:0] BASE_E = AE'(BASE_ADDR);
  localparam logic [AE-1:0] DEPTH_E = AE'(DEPTH);
  state_t state_q, state_d;
  logic we_q, we_d, gnt_q, gnt_d, err_q, err_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic sel, sel_we, legal, acc;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic [AE-1:0] ext, off;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign sel = (req0 & req1) ? ~last_q : req1;
`else
  assign sel = ~req0;
`endif
  assign sel_we    = sel ? we1 : we0;
  assign sel_addr  = sel ? addr1 : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;
  // one extra bit keeps the window compare from wrapping near the top of the address space
  assign ext   = {1'b0, sel_addr};
  assign off   = ext - BASE_E;
  assign legal = (sel_addr[1:0] == 2'b00) && (ext >= BASE_E) && ((off >> 2) < DEPTH_E);
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (req0 | req1) begin
        gnt_d   = sel;
        we_d    = sel_we;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        err_d   = ~legal;
        rdata_d = '0;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = legal ? ACCESS : DONE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = sel;
`endif
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end
  assign acc       = (state_q == ACCESS);
  assign ready0    = (state_q == DONE) & ~gnt_q;
  assign ready1    = (state_q == DONE) & gnt_q;
  assign err       = (state_q == DONE) & err_q;
  assign rdata     = (state_q == DONE) ? rdata_q : '0;
  assign freeze    = req0 & ~ready0;
  assign mem_addr  = acc ? addr_q : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign mem_read  = acc & ~we_q;
  assign mem_write = acc & we_q & (cnt_q == 4'd0);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural memory behind it.
module tb_mem_access_ctrl;
  localparam int WC = 3;
  localparam int DEPTH = 65465;
  localparam logic [31:0] BASE = 32'd1024;
  logic clk = 1'b0;
  logic rst, req0, req1, we0, we1, ready0, ready1, err, freeze, mem_read, mem_write;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0, failures = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, n_rdy = 0, ev_rd = 0;
  logic [31:0] waddr = '0;
  bit [31:0] mem [DEPTH];
  logic [31:0] model [int];
  logic pl_en = 1'b0;
  int pl_idx = 0;
  logic [31:0] pl_val = '0;
  int midx;
  typedef struct {bit p; bit e; logic [31:0] d;} exp_t;
  typedef struct {logic [1:0] r; logic e; logic [31:0] d; int c;} ev_t;
  exp_t sb[$];
  ev_t evs [256];

  mem_access_ctrl #(.WORD_SIZE(32), .ADDRESS_SIZE(32), .BASE_ADDR(1024), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .rdata(rdata), .err(err), .freeze(freeze),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign midx = int'((mem_addr - BASE) >> 2);
  assign mem_rdata = (mem_read && midx >= 0 && midx < DEPTH) ? mem[midx] : '0;
  always @(posedge clk)
    if (mem_write && midx >= 0 && midx < DEPTH) mem[midx] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_val;

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      waddr = mem_addr;
    end
    if (mem_read && mem_write) both_cnt++;
    if ((ready0 || ready1) && n_rdy < 256) begin
      evs[n_rdy].r = {ready1, ready0};
      evs[n_rdy].e = err;
      evs[n_rdy].d = rdata;
      evs[n_rdy].c = cyc;
      n_rdy++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl(input int i);
    return model.exists(i) ? model[i] : 32'd0;
  endfunction

  task automatic pre(input int i, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = i; pl_val = v; model[i] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push(input bit p, input bit e, input logic [31:0] d);
    exp_t x;
    x.p = p; x.e = e; x.d = d;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (ev_rd < n_rdy && ev_rd < 256) begin
      if (sb.size() == 0) chk("extra_ready", 32'(evs[ev_rd].r), 32'd0);
      else begin
        x = sb.pop_front();
        chk("port", 32'(evs[ev_rd].r), x.p ? 32'd2 : 32'd1);
        chk("err", 32'(evs[ev_rd].e), 32'(x.e));
        chk("rdata", evs[ev_rd].d, x.d);
      end
      ev_rd++;
    end
  endtask

  task automatic wait_rdy(input string tag, input int target);
    for (int k = 0; k < 400 && n_rdy < target; k++) begin
      @(negedge clk); #1;
    end
    chk(tag, n_rdy, target);
  endtask

  task automatic acc(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [32:0] ea;
    bit legal;
    int idx, lat, t0, n0, r0, w0;
    ea = {1'b0, a};
    legal = (a[1:0] == 2'b00) && (ea >= 33'd1024) && (((ea - 33'd1024) >> 2) < 33'(DEPTH));
    idx = int'((a - BASE) >> 2);
    lat = legal ? WC + 2 : 1;
    push(p, !legal, (legal && !w) ? mdl(idx) : 32'd0);
    if (legal && w) model[idx] = d;
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    t0 = cyc; n0 = n_rdy; r0 = rd_cnt; w0 = wr_cnt;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (!p) chk("freeze", 32'(freeze), 32'((cyc - t0) != lat));
      if (n_rdy != n0) break;
    end
    chk("ready_count", n_rdy - n0, 1);
    chk("latency", evs[n0].c - t0, lat);
    chk("read_cycles", rd_cnt - r0, (legal && !w) ? WC + 1 : 0);
    chk("write_cycles", wr_cnt - w0, (legal && w) ? 1 : 0);
    if (legal && w) chk("write_addr", waddr, a);
    drain();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    int n0, w0;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'({ready1, ready0}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobe", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd1);
    req0 = 1'b0;
    pre(0, 32'hDEADBEEF);
    pre(3, 32'h0BADF00D);
    pre(DEPTH - 1, 32'h13579BDF);
    @(posedge clk); #1 rst = 1'b1;
    acc(0, 1'b0, 32'd1024, 32'd0);
    acc(0, 1'b1, 32'd1028, 32'h12345678);
    acc(0, 1'b0, 32'd1028, 32'd0);
    acc(0, 1'b0, 32'd1000, 32'd0);
    acc(1, 1'b0, 32'd1026, 32'd0);
    acc(0, 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF0000);
    acc(1, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'd0);
    // contention starts from reset so the first round-robin grant is port 0
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1 rst = 1'b1;
    n0 = n_rdy;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      push(k[0], 1'b0, k[0] ? 32'h0BADF00D : 32'hDEADBEEF);
`else
      push(1'b0, 1'b0, 32'hDEADBEEF);
`endif
    end
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1024; req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1036;
    wait_rdy("contention_count", n0 + 4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    drain();
    n0 = n_rdy; w0 = wr_cnt;
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd1032; wdata1 = 32'hAAAA5555;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; req1 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("rst_abort_write", wr_cnt - w0, 0);
    chk("rst_abort_mem", mem[2], mdl(2));
    chk("rst_abort_ready", n_rdy - n0, 0);
    chk("rst_abort_strobe", 32'({mem_read, mem_write}), 32'd0);
    acc(1, 1'b1, 32'd1032, 32'h55AA55AA);
    acc(1, 1'b0, 32'd1032, 32'd0);
    n0 = n_rdy;
    push(1'b1, 1'b0, mdl(3));
    push(1'b1, 1'b0, mdl(3));
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1036;
    wait_rdy("b2b_count", n0 + 2);
    @(posedge clk); #1 req1 = 1'b0;
    chk("b2b_gap", evs[n0 + 1].c - evs[n0].c, WC + 3);
    drain();
    repeat (5) @(posedge clk);
    drain();
    chk("sb_left", sb.size(), 0);
    chk("rw_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Two-port access controller sitting in front of the single-ported data memory. It arbitrates between the pipeline MEM stage (port 0) and a loader/debug port (port 1), sequences each granted access over a configurable number of wait states, and range-checks addresses against the memory window. It returns a one-cycle ready pulse with read data, and generates the pipeline freeze while the MEM stage is stalled.

## Interface
- WORD_SIZE, 32, data width
- ADDRESS_SIZE, 32, byte-address width
- BASE_ADDR, 1024, first byte address mapped to memory word 0
- DEPTH, 65465, number of words in the backing memory
- WAIT_CYCLES, 1, extra cycles each access holds the memory bus (0..15)

Ports:
- clk  in  1  clock. Everything updates on posedge.
- rst  in  1  synchronous, active-low reset.
- req0, req1  in  1  access request from port 0 (MEM stage) and port 1 (loader).
- we0, we1  in  1  1 = write, 0 = read. Held with the request.
- addr0, addr1  in  ADDRESS_SIZE  byte address. Held with the request.
- wdata0, wdata1  in  WORD_SIZE  write data. Held with the request.
- ready0, ready1  out  1  one-cycle completion pulse for each port.
- rdata  out  WORD_SIZE  read data. Valid while the matching ready is high.
- err  out  1  access rejected. Valid while ready is high.
- freeze  out  1  pipeline stall, defined as req0 & ~ready0 (combinational).
- mem_addr  out  ADDRESS_SIZE  byte address driven to memory.
- mem_wdata  out  WORD_SIZE  write data driven to memory.
- mem_read, mem_write  out  1  memory strobes.
- mem_rdata  in  WORD_SIZE  combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - Samples req0 and req1.
  - If neither is set, stay in IDLE.
  - Otherwise select one port (see Configuration) and latch its we, addr and wdata into internal registers. Later changes on the inputs are ignored.
  - Check the latched address:
    - Legal only when addr[1:0]==0, addr>=BASE_ADDR and ((addr-BASE_ADDR)>>2) < DEPTH.
    - Compute in ADDRESS_SIZE+1 bits so nothing wraps.
    - Legal address: go to ACCESS and load the wait counter with WAIT_CYCLES.
    - Illegal address: go straight to DONE with the error flag set. No memory strobe is asserted.
- ACCESS
  - mem_addr and mem_wdata come from the latched registers.
  - mem_read stays high throughout for reads.
  - The counter decrements each cycle.
  - When the counter is 0:
    - Reads capture mem_rdata into the rdata register.
    - Writes assert mem_write for exactly this one cycle.
    - Go to DONE.
- DONE
  - Pulse ready for the granted port.
  - err = error flag.
  - rdata = captured data. It is 0 for writes and errors.
  - Go to IDLE.
- Requester rules:
  - Keep req and operands stable until ready.
  - To issue back-to-back accesses, keep req high on the ready cycle. It is re-sampled in IDLE on the next cycle.
- mem_read and mem_write are never high at the same time, and both are low outside ACCESS.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins first).
  - ready0=ready1=0, err=0, rdata=0.
  - mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
  - freeze follows req0.
- Legal access with req seen in IDLE at cycle 0:
  - ACCESS covers cycles 1..WAIT_CYCLES+1.
  - ready is high on cycle WAIT_CYCLES+2.
  - Next sample in IDLE is on cycle WAIT_CYCLES+3.
- Illegal access: ready and err are high on cycle 1.
- Both requests in the same IDLE cycle: exactly one port is granted. The other keeps waiting with no ready.
- Reset mid-access:
  - Return to IDLE and drop the transaction.
  - If reset lands before the write cycle, no write is performed.
  - ready is not pulsed.
- freeze drops in the same cycle ready0 rises. This lets the MEM stage advance on that edge.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests go to the port not granted last.
  - last_grant updates on every grant.
- MEM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, port 0 always wins.
  - last_grant is not implemented.
  - Port 1 is served only in IDLE cycles where req0 is low.

## Test plan
- Read, WAIT_CYCLES=1:
  - Preload word 0 = 32'hDEADBEEF, then req0 read at addr0=1024.
  - mem_read is high for 2 cycles.
  - ready0 pulses on cycle 3 with rdata=32'hDEADBEEF and err=0.
  - freeze is high on cycles 0–2.
- Write then read:
  - req0 write of 32'h12345678 to addr 1028.
  - mem_write is high for exactly 1 cycle with mem_addr=1028.
  - A following read of 1028 returns 32'h12345678.
- Illegal addresses, each request separately:
  - Requests to addr 1000, addr 1026, and BASE_ADDR+4*DEPTH.
  - Each gets ready plus err on cycle 1, rdata=0, and no memory strobes.
- Contention:
  - req0 and req1 both held high across 4 accesses.
  - With the macro: grants go 0, 1, 0, 1.
  - Without it: port 0 only, and ready1 never pulses.
- Reset mid-write:
  - WAIT_CYCLES=3; pull rst low on cycle 2 of a port 1 write.
  - Target word is unchanged, no ready pulse, state=IDLE.
  - Next request completes normally.
- Back-to-back: req1 held high for two reads. The second ready1 comes WAIT_CYCLES+3 cycles after the first.
